// File: rtl/lsu.sv
// Load-store unit for the single-cycle RV32I core.
//
// The ALU result arrives as the effective address and rs2 as the store data.
// The unit decodes the address into data memory or memory-mapped I/O, performs
// byte/half/word accesses with sign or zero extension, holds the board output
// registers and synchronises the board switches and buttons.
//
// Ports:
//   i_clk, i_rst_n           core clock, asynchronous active-low reset
//   i_lsu_addr               effective address
//   i_st_data                store data (rs2)
//   i_lsu_wren               store enable
//   i_ld_st_type             funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_ld_data                extended load result (combinational)
//   o_lsu_misaligned         misaligned access flag (combinational)
//   o_io_ledr, o_io_ledg     red / green LED registers
//   o_io_hex0..o_io_hex7     seven-segment digits
//   o_io_lcd                 LCD control register
//   i_io_sw, i_io_btn        asynchronous board switches / buttons
module lsu #(
  parameter int DMEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_ld_st_type,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  localparam logic [3:0] R_NONE  = 4'd0;
  localparam logic [3:0] R_DMEM  = 4'd1;
  localparam logic [3:0] R_LEDR  = 4'd2;
  localparam logic [3:0] R_LEDG  = 4'd3;
  localparam logic [3:0] R_HEXLO = 4'd4;
  localparam logic [3:0] R_HEXHI = 4'd5;
  localparam logic [3:0] R_LCD   = 4'd6;
  localparam logic [3:0] R_SW    = 4'd7;
  localparam logic [3:0] R_BTN   = 4'd8;

  // Extension helpers: the extracted lane is treated as a signed quantity so
  // the sign bit propagation is explicit.
  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] zext8(input logic [7:0] b);
    return {24'd0, b};
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic signed [31:0] zext16(input logic [15:0] h);
    return {16'd0, h};
  endfunction

  // Byte-lane write enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [2:0] t, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (t)
      T_B:     m = 4'b0001 << lane;
      T_H:     m = lane[1] ? 4'b1100 : 4'b0011;
      T_W:     m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] lane_data(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      T_B:     r = {4{d[7:0]}};
      T_H:     r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] ledr_q;
  logic [31:0] ledg_q;
  logic [31:0] hex_lo_q;
  logic [31:0] hex_hi_q;
  logic [31:0] lcd_q;
  logic [31:0] sw_p0;
  logic [31:0] sw_p1;
  logic [3:0]  btn_p0;
  logic [3:0]  btn_p1;

  logic [3:0]       region;
  logic [IDX_W-1:0] dmem_idx;
  logic [1:0]       lane;
  logic             is_half;
  logic             is_word;
  logic             ld_type_ok;
  logic             st_type_ok;
  logic             misaligned;
  logic             region_rw;
  logic             commit;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rd_word;
  logic [31:0]      lane_shift;
  logic [31:0]      half_shift;
  logic signed [31:0] ld_ext;

  assign dmem_idx = i_lsu_addr[IDX_W+1:2];
  assign lane     = i_lsu_addr[1:0];

  // DMEM decode is exact on the upper bits so addresses past the array end
  // fall into the unmapped region rather than aliasing.
  always_comb begin
    region = R_NONE;
    if (i_lsu_addr[31:IDX_W+2] == '0) begin
      region = R_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        20'h10000: region = R_LEDR;
        20'h10001: region = R_LEDG;
        20'h10002: region = R_HEXLO;
        20'h10003: region = R_HEXHI;
        20'h10004: region = R_LCD;
        20'h10010: region = R_SW;
        20'h10011: region = R_BTN;
        default:   region = R_NONE;
      endcase
    end
  end

  always_comb begin
    is_half    = (i_ld_st_type == T_H) || (i_ld_st_type == T_HU);
    is_word    = (i_ld_st_type == T_W);
    ld_type_ok = (i_ld_st_type == T_B)  || (i_ld_st_type == T_H) ||
                 (i_ld_st_type == T_W)  || (i_ld_st_type == T_BU) ||
                 (i_ld_st_type == T_HU);
    // BU/HU are load-only encodings; they never write.
    st_type_ok = (i_ld_st_type == T_B) || (i_ld_st_type == T_H) ||
                 (i_ld_st_type == T_W);
    misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    region_rw  = (region == R_DMEM)  || (region == R_LEDR)  ||
                 (region == R_LEDG)  || (region == R_HEXLO) ||
                 (region == R_HEXHI) || (region == R_LCD);
    // Reset gating keeps the un-reset DMEM from taking a store while the rest
    // of the block is held in reset.
    commit     = i_rst_n && i_lsu_wren && st_type_ok && !misaligned && region_rw;
    be         = lane_mask(i_ld_st_type, lane);
    wdata      = lane_data(i_ld_st_type, i_st_data);
  end

  assign o_lsu_misaligned = misaligned;

  // Stage p0 -> p1: read mux and lane extraction, all combinational.
  always_comb begin
    case (region)
      R_DMEM:  rd_word = dmem[dmem_idx];
      R_LEDR:  rd_word = ledr_q;
      R_LEDG:  rd_word = ledg_q;
      R_HEXLO: rd_word = hex_lo_q;
      R_HEXHI: rd_word = hex_hi_q;
      R_LCD:   rd_word = lcd_q;
      R_SW:    rd_word = sw_p1;
      R_BTN:   rd_word = {28'd0, btn_p1};
      default: rd_word = 32'd0;
    endcase
    lane_shift = rd_word >> {lane, 3'b000};
    half_shift = rd_word >> {lane[1], 4'b0000};
    case (i_ld_st_type)
      T_B:     ld_ext = sext8(lane_shift[7:0]);
      T_BU:    ld_ext = zext8(lane_shift[7:0]);
      T_H:     ld_ext = sext16(half_shift[15:0]);
      T_HU:    ld_ext = zext16(half_shift[15:0]);
      default: ld_ext = rd_word;
    endcase
    if (ld_type_ok && !misaligned && (region != R_NONE)) begin
      o_ld_data = ld_ext;
    end else begin
      o_ld_data = 32'd0;
    end
  end

  // Data memory: no reset, per-byte write enable.
  always_ff @(posedge i_clk) begin
    if (commit && (region == R_DMEM)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Board output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q   <= 32'd0;
      ledg_q   <= 32'd0;
      hex_lo_q <= 32'd0;
      hex_hi_q <= 32'd0;
      lcd_q    <= 32'd0;
    end else if (commit) begin
      case (region)
        R_LEDR:  ledr_q   <= merge_bytes(ledr_q,   wdata, be);
        R_LEDG:  ledg_q   <= merge_bytes(ledg_q,   wdata, be);
        R_HEXLO: hex_lo_q <= merge_bytes(hex_lo_q, wdata, be);
        R_HEXHI: hex_hi_q <= merge_bytes(hex_hi_q, wdata, be);
        R_LCD:   lcd_q    <= merge_bytes(lcd_q,    wdata, be);
        default: ;
      endcase
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_p0  <= 32'd0;
      sw_p1  <= 32'd0;
      btn_p0 <= 4'd0;
      btn_p1 <= 4'd0;
    end else begin
      sw_p0  <= i_io_sw;
      sw_p1  <= sw_p0;
      btn_p0 <= i_io_btn;
      btn_p1 <= btn_p0;
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_lo_q[6:0];
  assign o_io_hex1 = hex_lo_q[14:8];
  assign o_io_hex2 = hex_lo_q[22:16];
  assign o_io_hex3 = hex_lo_q[30:24];
  assign o_io_hex4 = hex_hi_q[6:0];
  assign o_io_hex5 = hex_hi_q[14:8];
  assign o_io_hex6 = hex_hi_q[22:16];
  assign o_io_hex7 = hex_hi_q[30:24];

endmodule

// File: doc/lsu.md
# lsu

Load-store unit for the single-cycle RV32I core. It sits directly downstream of the ALU: the ALU result is the effective address, and the register-file rs2 value is the store data. The block decodes the address into data memory and memory-mapped I/O, performs byte, half and word accesses with sign or zero extension, and holds the board output registers. It also synchronises the board inputs.

## Interface
- DMEM_WORDS, 512, data-memory depth in 32-bit words (2 KiB).
- i_clk  in  1  core clock; every state update happens on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lsu_addr  in  32  effective address from the ALU.
- i_st_data  in  32  store data (rs2).
- i_lsu_wren  in  1  store enable for this instruction.
- i_ld_st_type  in  3  funct3 encoding:
  - 000 = B, 001 = H, 010 = W
  - 100 = BU, 101 = HU
  - other values are illegal.
- o_ld_data  out  32  extended load result (combinational).
- o_lsu_misaligned  out  1  misaligned access flag (combinational).
- o_io_ledr  out  32  red LED register.
- o_io_ledg  out  32  green LED register.
- o_io_hex0 … o_io_hex7  out  7 each  seven-segment digits.
- o_io_lcd  out  32  LCD control register.
- i_io_sw  in  32  board switches (asynchronous).
- i_io_btn  in  4  board buttons (asynchronous).

## Operation
- Address decode uses i_lsu_addr[31:12] for the region and [1:0] for the byte lane:
  - 0x0000_0000–0x0000_07FF: DMEM, read/write.
  - 0x1000_0xxx: LEDR, R/W.
  - 0x1000_1xxx: LEDG, R/W.
  - 0x1000_2xxx: HEX0–3, R/W. Byte k holds hex(k) in bits [6:0]; bit 7 of each byte is stored and reads back.
  - 0x1000_3xxx: HEX4–7, R/W, same layout.
  - 0x1000_4xxx: LCD, R/W.
  - 0x1001_0xxx: SW, read-only.
  - 0x1001_1xxx: BTN, read-only; bits [3:0] are the buttons, upper bits read 0.
  - Any other address is unmapped.
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00. Otherwise o_lsu_misaligned=1.
- A store is committed only if all of the following hold: i_lsu_wren=1, the access is aligned, the type is legal (B/H/W), and the region is R/W.
  - B writes only lane addr[1:0].
  - H writes lanes {addr[1],0} and {addr[1],1}.
  - W writes all four lanes.
  - Unselected lanes keep their value.
- Loads:
  - The aligned word is read, and the byte or half at the lane is extracted.
  - B/H sign-extend; BU/HU zero-extend.
  - Misaligned, illegal-type or unmapped loads return 0x0000_0000.
- BU/HU with i_lsu_wren=1 is illegal: no write.
- DMEM is a word array indexed by addr[10:2] with per-byte write enable. It has no reset; contents are undefined until written.
- Inputs: i_io_sw and i_io_btn each pass through a 2-flop synchroniser. Reads of SW and BTN return the second flop.

## Timing
- Reset (i_rst_n=0, asynchronous) clears immediately:
  - LEDR, LEDG, LCD and all HEX bytes → 0.
  - Synchroniser flops → 0.
  - DMEM is untouched.
- While i_rst_n=0, no store commits. A store whose edge coincides with reset assertion is dropped.
- Store latency: the value is visible on the output ports and on reads one cycle after the edge where i_lsu_wren=1.
- Load latency: o_ld_data is combinational from i_lsu_addr, the stored state and i_ld_st_type in the same cycle (0 cycles).
- Load and store to the same address in one cycle: o_ld_data shows the old value before the edge and the new value after it.
- o_lsu_misaligned is purely combinational. It is asserted regardless of i_lsu_wren.
- Switch/button latency: a change on i_io_sw is visible on a SW read after 2 rising edges.
- Address wrap: DMEM decode is exact. 0x0000_0800 is unmapped and does not alias to 0x0.

## Test plan
- Reset with i_rst_n=0 mid-run:
  - All I/O outputs read 0 asynchronously.
  - After release, LW of 0x1000_0000 → 0x0000_0000.
- SW 0xDEADBEEF to 0x100, SB 0x7F to 0x101, then load 0x100:
  - LW 0x100 → 0xDEAD7FEF.
  - LB 0x103 → 0xFFFFFFDE.
  - LBU 0x103 → 0x000000DE.
  - LH 0x102 → 0xFFFFDEAD.
  - LHU 0x102 → 0x0000DEAD.
- SH to 0x101, then LW to 0x102:
  - o_lsu_misaligned=1 for both.
  - Memory is unchanged and the load returns 0.
- SW 0x12345678 to 0x1000_2000:
  - Next cycle o_io_hex0=0x78, o_io_hex1=0x56, o_io_hex2=0x34, o_io_hex3=0x12.
  - Follow with SB 0x40 to 0x1000_2001 → o_io_hex1=0x40 only.
- Set i_io_sw=0xA5A5_0001:
  - LW 0x1001_0000 returns the old value after 1 edge and 0xA5A5_0001 after 2 edges.
  - SW to 0x1001_0000 has no effect.
- Unmapped accesses:
  - SW to 0x2000_0000: no output changes.
  - LW from 0x2000_0000 and from 0x0000_0800 → 0.
